mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit controller for the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and sequences the external `mul` (fixed latency) and `div` (start/ready handshake) datapaths. Raises the EX stall request while an operation is in flight and owns the architectural HI/LO registers, whose values EX reads for MFHI/MFLO.

## Interface
**Parameters**
- `MUL_LAT`, default 2: cycles from stable `mul_ina`/`mul_inb` to valid `mul_result`; legal range 1..15.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: annuls the in-flight operation.
- `op_valid` in 1: EX holds an MDU instruction this cycle.
- `op` in 3: operation select.
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
  - 11x is a no-op.
- `src1`, `src2` in 32: rs and rt operand values.
- `stallreq` out 1: EX stall request to the ctrl stall bus.
- `busy` out 1: state is not IDLE.
- `mul_signed` out 1; `mul_ina`, `mul_inb` out 32: multiplier operands.
- `mul_result` in 64: multiplier product.
- `div_start` out 1; `div_annul` out 1; `div_signed` out 1; `div_op1`, `div_op2` out 32: divider controls and operands.
- `div_result` in 64: {remainder, quotient}.
- `div_ready` in 1: divider result valid.
- `hi_o`, `lo_o` out 32: current HI/LO values.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Operand latch:** `src1`, `src2` and signedness are captured on IDLE exit. All datapath outputs are driven from these latched values. In IDLE, all datapath outputs are 0.
- **IDLE**
  - `op_valid` and mult/multu → MUL, counter cleared.
  - `op_valid` and div/divu → DIV.
  - `op_valid` and mthi → HI ← `src1` at this edge; stay IDLE; no stall.
  - `op_valid` and mtlo → LO ← `src1` at this edge; stay IDLE; no stall.
- **MUL**
  - Counter increments each cycle.
  - When counter == `MUL_LAT`-1: HI ← `mul_result[63:32]`, LO ← `mul_result[31:0]`, → DONE.
- **DIV**
  - `div_start` = ~`div_ready`.
  - When `div_ready`: HI ← `div_result[63:32]`, LO ← `div_result[31:0]`, `div_start` = 0, → DONE.
- **DONE**
  - `stallreq` = 0, so the instruction leaves EX.
  - → IDLE unconditionally.
- **`stallreq`** = `op_valid` & (op ∈ mult/multu/div/divu) & (state ≠ DONE). This is combinational, so EX stalls in the issue cycle.
- **`flush`**
  - Has priority over every other condition: any state → IDLE, HI/LO not written.
  - If the state was DIV, `div_annul` = 1 and `div_start` = 0 in the `flush` cycle.
  - If the state was IDLE, a same-cycle `mthi`/`mtlo` write is suppressed.
- **`rst`:** state IDLE, counter 0, HI = LO = 0. All outputs are 0 in the cycle after `rst`.
- **`op_valid` low in MUL/DIV:** the operation continues to completion; HI/LO are still written.

## Timing
- mult/multu issued at cycle 0:
  - `stallreq` high in cycles 0..`MUL_LAT`.
  - HI/LO updated at the end of cycle `MUL_LAT`.
  - DONE in cycle `MUL_LAT`+1.
  - Total EX residency `MUL_LAT`+2 cycles.
- div/divu:
  - `stallreq` high from cycle 0 through the cycle `div_ready` is seen.
  - DONE in the following cycle.
- mthi/mtlo: `hi_o`/`lo_o` show the new value from the next cycle onward. There is no same-cycle bypass.
- Back-to-back MDU instructions: the second one sees IDLE in the cycle after DONE; there are no lost cycles beyond that.

## Configuration
- **`MDU_DIV0_BYPASS_EN` defined:**
  - div/divu with `src2` == 0 goes IDLE → DONE directly; the divider is never started.
  - HI ← `src1`, LO ← 32'hFFFF_FFFF.
  - `stallreq` is high for cycle 0 only.
- **`MDU_DIV0_BYPASS_EN` undefined:** a zero divisor is issued to the divider like any other division, and HI/LO take whatever the divider returns.

## Test plan
- **Reset, then multu:** `rst` 1 cycle, then multu 0xFFFF_FFFF × 2 with `MUL_LAT`=2 → `stallreq` high exactly 3 cycles, then HI=0x1, LO=0xFFFF_FFFE.
- **Signed mult:** mult −3 × 5 → `mul_signed`=1, HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
- **Signed div:** div 7 / −2 with divider model ready after 34 cycles → `div_start` high until ready, HI=1, LO=0xFFFF_FFFD, `stallreq` drops in the DONE cycle.
- **mthi then mtlo:** mthi 0x1234, next cycle mtlo 0x5678 → no `stallreq`; `hi_o`=0x1234 from cycle 1, `lo_o`=0x5678 from cycle 2.
- **Flush mid-divide:** `flush` in the 10th cycle of a divu → `div_annul` pulses 1 cycle, state returns to IDLE, HI/LO keep their prior values, a following multu completes normally.
- **Divide by zero:** div 9 / 0 → with `MDU_DIV0_BYPASS_EN`: 1 stall cycle, HI=9, LO=0xFFFF_FFFF, `div_start` never asserted; without it: `div_start` is asserted.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: sequences fixed-latency mul and handshaked div, owns HI/LO.
// Optional feature: define MDU_DIV0_BYPASS_EN to complete divide-by-zero without the divider.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic is_mul, is_div, in_mul, in_div;

  assign is_mul = (op == 3'b000) || (op == 3'b001);
  assign is_div = (op == 3'b010) || (op == 3'b011);
  assign in_mul = (state_q == MUL);
  assign in_div = (state_q == DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (op_valid) begin
            if (is_mul) begin
              state_d = MUL;
              cnt_d   = '0;
              a_d     = src1;
              b_d     = src2;
              sgn_d   = ~op[0];
            end else if (is_div) begin
              a_d   = src1;
              b_d   = src2;
              sgn_d = ~op[0];
`ifdef MDU_DIV0_BYPASS_EN
              if (src2 == '0) begin
                state_d = DONE;
                hi_d    = src1;
                lo_d    = '1;
              end else
`endif
              state_d = DIV;
            end else if (op == 3'b100) begin
              hi_d = src1;
            end else if (op == 3'b101) begin
              lo_d = src1;
            end
          end
        end
        MUL: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(MUL_LAT - 1)) begin
            hi_d    = mul_result[63:32];
            lo_d    = mul_result[31:0];
            state_d = DONE;
          end
        end
        DIV: begin
          if (div_ready) begin
            hi_d    = div_result[63:32];
            lo_d    = div_result[31:0];
            state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall and divider handshake are combinational so EX stalls in the issue cycle.
  assign stallreq   = op_valid && (is_mul || is_div) && (state_q != DONE);
  assign busy       = (state_q != IDLE);
  assign mul_signed = in_mul & sgn_q;
  assign mul_ina    = in_mul ? a_q : '0;
  assign mul_inb    = in_mul ? b_q : '0;
  assign div_start  = in_div & ~div_ready & ~flush;
  assign div_annul  = in_div & flush;
  assign div_signed = in_div & sgn_q;
  assign div_op1    = in_div ? a_q : '0;
  assign div_op2    = in_div ? b_q : '0;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with behavioural mul (MUL_LAT=2) and div (34-cycle) models.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        stallreq, busy, mul_signed, div_start, div_annul, div_signed, div_ready;
  logic [31:0] mul_ina, mul_inb, div_op1, div_op2, hi_o, lo_o;
  logic [63:0] mul_result, div_result;

  int checks = 0;
  int errors = 0;
  int st, sc;
  logic sg;
  logic [31:0] hi_save, lo_save;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
    .src1(src1), .src2(src2), .stallreq(stallreq), .busy(busy),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2), .div_result(div_result), .div_ready(div_ready),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // Multiplier model: one register stage, result valid in the 2nd cycle of stable operands.
  logic [63:0] ext_a, ext_b;
  assign ext_a = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'h0, mul_ina};
  assign ext_b = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'h0, mul_inb};
  always @(posedge clk) mul_result <= ext_a * ext_b;

  // Divider model: ready after 34 cycles of div_start.
  int div_cnt = 0;
  assign div_ready = (div_cnt == 34);
  always @(posedge clk) begin
    if (div_ready || div_annul) div_cnt <= 0;
    else if (div_start) div_cnt <= div_cnt + 1;
  end
  logic signed [31:0] sq, sr;
  always_comb begin
    sq = '0;
    sr = '0;
    if (div_op2 == '0) div_result = {div_op1, 32'hFFFF_FFFF};
    else if (div_signed) begin
      sq = $signed(div_op1) / $signed(div_op2);
      sr = $signed(div_op1) % $signed(div_op2);
      div_result = {sr, sq};
    end else div_result = {div_op1 % div_op2, div_op1 / div_op2};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the instruction in EX until stallreq drops, then retires it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int starts, output logic sawsgn);
    stalls = 0;
    starts = 0;
    sawsgn = 1'b0;
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stallreq) break;
      stalls++;
      if (div_start) starts++;
      if (mul_signed) sawsgn = 1'b1;
      tick();
    end
    tick();
    op_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", {63'h0, stallreq}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_hilo", {hi_o, lo_o}, 64'h0);
    chk("rst_dp", {div_start, div_annul, mul_ina, div_op1}, 66'h0);
    tick();

    run_op(3'b001, 32'hFFFF_FFFF, 32'h2, st, sc, sg);
    chk("multu_stall", 64'(st), 64'd3);
    chk("multu_sgn", {63'h0, sg}, 64'h0);
    chk("multu_hilo", {hi_o, lo_o}, 64'h1_FFFF_FFFE);
    chk("multu_idle", {63'h0, busy}, 64'h0);

    run_op(3'b000, 32'hFFFF_FFFD, 32'h5, st, sc, sg);
    chk("mult_sgn", {63'h0, sg}, 64'h1);
    chk("mult_stall", 64'(st), 64'd3);
    chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);

    run_op(3'b010, 32'h7, 32'hFFFF_FFFE, st, sc, sg);
    chk("div_stall", 64'(st), 64'd36);
    chk("div_starts", 64'(sc), 64'd34);
    chk("div_hilo", {hi_o, lo_o}, 64'h1_FFFF_FFFD);

    run_op(3'b100, 32'h1234, 32'h0, st, sc, sg);
    chk("mthi_stall", 64'(st), 64'd0);
    chk("mthi_hi", {hi_o, lo_o}, 64'h1234_FFFF_FFFD);
    run_op(3'b101, 32'h5678, 32'h0, st, sc, sg);
    chk("mtlo_stall", 64'(st), 64'd0);
    chk("mtlo_lo", {hi_o, lo_o}, 64'h1234_0000_5678);

    // mthi in the same cycle as flush must not write HI
    op_valid = 1'b1; op = 3'b100; src1 = 32'hDEAD; flush = 1'b1;
    tick();
    op_valid = 1'b0; flush = 1'b0;
    chk("flush_mthi", {32'h0, hi_o}, 64'h1234);

    // no-op encoding: no stall, stays idle
    op_valid = 1'b1; op = 3'b110; src1 = 32'h99;
    #1;
    chk("nop_stall", {63'h0, stallreq}, 64'h0);
    tick();
    op_valid = 1'b0;
    chk("nop_hilo", {hi_o, lo_o, 63'h0, busy}, {64'h1234_0000_5678, 64'h0});

    hi_save = hi_o; lo_save = lo_o;
    op_valid = 1'b1; op = 3'b011; src1 = 32'd100; src2 = 32'd7;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    #1;
    chk("flush_annul", {62'h0, div_annul, div_start}, 64'h2);
    tick();
    flush = 1'b0; op_valid = 1'b0;
    chk("flush_after", {62'h0, div_annul, busy}, 64'h0);
    chk("flush_hilo", {hi_o, lo_o}, {hi_save, lo_save});
    tick();
    run_op(3'b001, 32'd3, 32'd4, st, sc, sg);
    chk("post_flush_stall", 64'(st), 64'd3);
    chk("post_flush_hilo", {hi_o, lo_o}, 64'd12);

    // mult completes with op_valid dropped after issue
    op_valid = 1'b1; op = 3'b000; src1 = 32'd6; src2 = 32'd7;
    tick();
    op_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("bg_done_busy", {63'h0, busy}, 64'h1);
    tick();
    chk("bg_hilo", {hi_o, lo_o, 63'h0, busy}, {64'd42, 64'h0});

    run_op(3'b010, 32'd9, 32'd0, st, sc, sg);
    chk("div0_hilo", {hi_o, lo_o}, 64'h9_FFFF_FFFF);
`ifdef MDU_DIV0_BYPASS_EN
    chk("div0_stall", 64'(st), 64'd1);
    chk("div0_starts", 64'(sc), 64'd0);
`else
    chk("div0_stall", 64'(st), 64'd36);
    chk("div0_starts", 64'(sc), 64'd34);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
